// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands, opcode and carry enable in; result and flags out.
// Request side is valid/ready (in_valid/in_ready); response side is valid/ready (out_valid/out_ready).
// master = requester/consumer (testbench or upstream logic), slave = the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic             carry_ce;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o_main;
    logic [WIDTH-1:0] o_high;
    logic             carry_out;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, op, i_1, i_2, carry_ce, out_ready,
        input  in_ready, out_valid, o_main, o_high, carry_out, zero, neg, ovf
    );

    modport slave (
        input  in_valid, op, i_1, i_2, carry_ce, out_ready,
        output in_ready, out_valid, o_main, o_high, carry_out, zero, neg, ovf
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub/logic/neg/pass/adc/sbb in one cycle, unsigned shift-add multiply one bit per cycle.
// Latency: result registered on the cycle after accept; MUL spends WIDTH cycles busy, valid on the cycle after that.
// Backpressure: result and flags hold while out_valid && !out_ready; a new request is taken only when idle or the held result drains.
// Ports: clk, rst_n (async active-low); bus (alu_seq_if.slave) carrying the request, result, carry flag C and zero/neg/ovf.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NEG  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;
    localparam logic [3:0] OP_ADC  = 4'd7;
    localparam logic [3:0] OP_SBB  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               c_q, c_d;
    logic [WIDTH-1:0]   o_main_q, o_main_d;
    logic [WIDTH-1:0]   o_high_q, o_high_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_ce_q, mul_ce_d;

    logic               accept;
    logic [WIDTH-1:0]   a_op, b_op;
    logic               cin;
    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_c_wr, alu_ovf;
    logic [2*WIDTH-1:0] acc_next;

    assign a_op = bus.i_1;
    assign b_op = bus.i_2;

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.o_main    = o_main_q;
    assign bus.o_high    = o_high_q;
    assign bus.carry_out = c_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;

    // ADC/SBB fold the pre-update C in; one extra bit captures carry-out / borrow.
    assign cin   = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) && c_q;
    assign add_w = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    assign sub_w = {1'b0, a_op} - {1'b0, b_op} - {{WIDTH{1'b0}}, cin};

    // Single-cycle datapath; MUL is handled by the iterative path below.
    always_comb begin
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_c_wr = 1'b0;
        alu_ovf  = 1'b0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                alu_res  = add_w[WIDTH-1:0];
                alu_c    = add_w[WIDTH];
                alu_c_wr = 1'b1;
                alu_ovf  = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                alu_res  = sub_w[WIDTH-1:0];
                alu_c    = sub_w[WIDTH];  // wrapped negative difference == borrow
                alu_c_wr = 1'b1;
                alu_ovf  = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu_res[WIDTH-1] != a_op[WIDTH-1]);
            end
            OP_AND:  alu_res = a_op & b_op;
            OP_OR:   alu_res = a_op | b_op;
            OP_XOR:  alu_res = a_op ^ b_op;
            OP_NEG: begin
                alu_res  = ~a_op + WIDTH'(1);
                alu_c    = (a_op != '0);
                alu_c_wr = 1'b1;
                alu_ovf  = (a_op == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_PASS: alu_res = b_op;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the left-shifting multiplicand when the current multiplier bit is set.
    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        o_main_d = o_main_q;
        o_high_d = o_high_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        mul_ce_d = mul_ce_q;

        if (accept) begin
            if (bus.op == OP_MUL) begin
                state_d  = MUL_BUSY;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a_op};
                mplier_d = b_op;
                cnt_d    = '0;
                mul_ce_d = bus.carry_ce;
            end else begin
                state_d  = DONE;
                o_main_d = alu_res;
                o_high_d = '0;
                zero_d   = (alu_res == '0);
                neg_d    = alu_res[WIDTH-1];
                ovf_d    = alu_ovf;
                if (bus.carry_ce && alu_c_wr) begin
                    c_d = alu_c;
                end
            end
        end else begin
            case (state_q)
                MUL_BUSY: begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = DONE;
                        o_main_d = acc_next[WIDTH-1:0];
                        o_high_d = acc_next[2*WIDTH-1:WIDTH];
                        zero_d   = (acc_next == '0);
                        neg_d    = acc_next[2*WIDTH-1];
                        ovf_d    = 1'b0;
                        if (mul_ce_q) begin
                            c_d = (acc_next[2*WIDTH-1:WIDTH] != '0);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            c_q      <= 1'b0;
            o_main_q <= '0;
            o_high_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mul_ce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            o_main_q <= o_main_d;
            o_high_q <= o_high_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            mul_ce_q <= mul_ce_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed scenarios plus randomized ops against an arithmetic reference model.
// Inputs are driven away from the rising edge; outputs are sampled on the falling edge.
// Ends with one summary line of passed/total checks.
module tb_alu_seq;
    localparam int W = 8;

    typedef struct packed {
        logic [7:0] main;
        logic [7:0] high;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   m_c     = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic res_t observe();
        observe = {bus.o_main, bus.o_high, bus.carry_out, bus.zero, bus.neg, bus.ovf};
    endfunction

    // Reference: plain integer arithmetic on the operation rules; returns result, flags and the new C.
    function automatic res_t ref_op(input logic [3:0] op, input int a, input int b, input bit ce, input bit c_old);
        res_t r;
        int   full;
        int   ci;
        bit   wr;
        bit   cv;
        r = '0; full = 0; wr = 1'b0; cv = 1'b0;
        ci = c_old ? 1 : 0;
        case (op)
            4'd0, 4'd7: begin
                full   = a + b + ((op == 4'd7) ? ci : 0);
                r.main = full[7:0];
                cv     = (full > 255);
                wr     = 1'b1;
                r.v    = (a[7] == b[7]) && (r.main[7] != a[7]);
            end
            4'd1, 4'd8: begin
                full   = a - b - ((op == 4'd8) ? ci : 0);
                r.main = full[7:0];
                cv     = (a < b + ((op == 4'd8) ? ci : 0));
                wr     = 1'b1;
                r.v    = (a[7] != b[7]) && (r.main[7] != a[7]);
            end
            4'd2: begin full = a & b; r.main = full[7:0]; end
            4'd3: begin full = a | b; r.main = full[7:0]; end
            4'd4: begin full = a ^ b; r.main = full[7:0]; end
            4'd5: begin
                full   = 256 - a;
                r.main = full[7:0];
                cv     = (a != 0);
                wr     = 1'b1;
                r.v    = (a == 128);
            end
            4'd6: begin full = b; r.main = full[7:0]; end
            4'd9: begin
                full   = a * b;
                r.main = full[7:0];
                r.high = full[15:8];
                cv     = (r.high != 8'h00);
                wr     = 1'b1;
            end
            default: r.main = 8'h00;
        endcase
        r.z = (op == 4'd9) ? (full == 0) : (r.main == 8'h00);
        r.n = (op == 4'd9) ? r.high[7] : r.main[7];
        r.c = (ce && wr) ? cv : c_old;
        return r;
    endfunction

    // Presents one request (DUT must be able to accept at the next edge), then waits for out_valid.
    // Returns at a falling edge with the result visible; the caller decides whether to drain it.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input bit ce,
                         output res_t o, output int lat);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.i_1      = a;
        bus.i_2      = b;
        bus.carry_ce = ce;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.i_1      = 8'($urandom);
        bus.i_2      = 8'($urandom);
        bus.carry_ce = 1'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 40);
        o = observe();
        n_total++;
        if (!bus.out_valid) $display("FAIL issue_timeout: out_valid=%0b after %0d cycles, required 1", bus.out_valid, lat);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.op = 4'd0;
        bus.i_1 = 8'h00; bus.i_2 = 8'h00; bus.carry_ce = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, observe()} !== '0) $display("FAIL reset_outputs: got %h required 0", {bus.out_valid, observe()});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL reset_release: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        else n_pass++;
        m_c = 1'b0;
    endtask

    task automatic test_directed;
        res_t o;
        int   lat;
        bus.out_ready = 1'b1;
        issue(4'd0, 8'hF0, 8'h20, 1'b1, o, lat);
        n_total++;
        if ({lat, o} !== {32'd1, res_t'{8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0}})
            $display("FAIL add_f0_20: lat=%0d res=%h required lat=1 res=%h", lat, o, res_t'{8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        else n_pass++;
        issue(4'd7, 8'h01, 8'h01, 1'b1, o, lat);
        n_total++;
        if (o !== res_t'{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) $display("FAIL adc_with_c: got %h required %h", o, res_t'{8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
        else n_pass++;
        issue(4'd1, 8'h80, 8'h01, 1'b1, o, lat);
        n_total++;
        if (o !== res_t'{8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) $display("FAIL sub_80_01: got %h required %h", o, res_t'{8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        else n_pass++;
        issue(4'd5, 8'h80, 8'h00, 1'b1, o, lat);
        n_total++;
        if (o !== res_t'{8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}) $display("FAIL neg_80: got %h required %h", o, res_t'{8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1});
        else n_pass++;
        issue(4'hF, 8'h55, 8'hAA, 1'b1, o, lat);
        n_total++;
        if (o !== res_t'{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}) $display("FAIL undef_op: got %h required %h", o, res_t'{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        else n_pass++;
        m_c = 1'b1;
    endtask

    task automatic test_mul;
        int lat;
        int busy;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.i_1 = 8'hFF; bus.i_2 = 8'hFF; bus.carry_ce = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; busy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
            if (!bus.in_ready) busy++;
        end
        n_total++;
        if (lat !== 9 || busy !== 8) $display("FAIL mul_timing: lat=%0d busy=%0d required lat=9 busy=8", lat, busy);
        else n_pass++;
        n_total++;
        if (observe() !== res_t'{8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0}) $display("FAIL mul_ff_ff: got %h required %h", observe(), res_t'{8'h01, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});
        else n_pass++;
        m_c = 1'b1;
    endtask

    task automatic test_reset_mid_mul;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = 4'd9; bus.i_1 = 8'h03; bus.i_2 = 8'h05; bus.carry_ce = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, observe()} !== '0) $display("FAIL reset_mid_mul: got %h required 0", {bus.out_valid, observe()});
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) $display("FAIL reset_mid_mul_release: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        else n_pass++;
        m_c = 1'b0;
    endtask

    task automatic test_back_to_back;
        bus.out_ready = 1'b1; bus.carry_ce = 1'b0; bus.op = 4'd0;
        bus.in_valid = 1'b1; bus.i_1 = 8'd1; bus.i_2 = 8'd1;
        @(posedge clk); #1;
        bus.i_1 = 8'd2; bus.i_2 = 8'd2;
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, bus.in_ready, bus.o_main} !== {2'b11, 8'h02}) $display("FAIL b2b_first: got %h required %h", {bus.out_valid, bus.in_ready, bus.o_main}, {2'b11, 8'h02});
        else n_pass++;
        @(posedge clk); #1;
        bus.i_1 = 8'd3; bus.i_2 = 8'd3;
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, bus.o_main} !== {1'b1, 8'h04}) $display("FAIL b2b_second: got %h required %h", {bus.out_valid, bus.o_main}, {1'b1, 8'h04});
        else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, bus.o_main} !== {1'b1, 8'h06}) $display("FAIL b2b_third: got %h required %h", {bus.out_valid, bus.o_main}, {1'b1, 8'h06});
        else n_pass++;
        // Stall: the first result must hold and no new request may be taken.
        bus.in_valid = 1'b1; bus.i_1 = 8'd1; bus.i_2 = 8'd1;
        @(posedge clk); #1;
        bus.i_1 = 8'd2; bus.i_2 = 8'd2;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if ({bus.out_valid, bus.in_ready, bus.o_main, bus.zero, bus.ovf} !== {2'b10, 8'h02, 2'b00})
                $display("FAIL stall_hold_%0d: got %h required %h", k, {bus.out_valid, bus.in_ready, bus.o_main, bus.zero, bus.ovf}, {2'b10, 8'h02, 2'b00});
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL stall_release: in_ready=%b required 1", bus.in_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, bus.o_main} !== {1'b1, 8'h04}) $display("FAIL stall_next: got %h required %h", {bus.out_valid, bus.o_main}, {1'b1, 8'h04});
        else n_pass++;
    endtask

    task automatic test_random;
        logic [7:0] corner [5];
        logic [3:0] op;
        logic [7:0] a, b;
        bit         ce;
        res_t       exp, o;
        int         lat, stall;
        corner = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 8'($urandom);
            ce = 1'($urandom);
            exp = ref_op(op, int'(a), int'(b), ce, m_c);
            issue(op, a, b, ce, o, lat);
            n_total++;
            if ({lat, o} !== {((op == 4'd9) ? 32'd9 : 32'd1), exp})
                $display("FAIL rand_%0d op=%0d a=%h b=%h ce=%0b: lat=%0d res=%h required lat=%0d res=%h",
                         i, op, a, b, ce, lat, o, (op == 4'd9) ? 9 : 1, exp);
            else n_pass++;
            m_c = exp.c;
            stall = $urandom_range(0, 3);
            if (stall > 0) begin
                bus.out_ready = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    @(negedge clk);
                    n_total++;
                    if ({bus.out_valid, bus.in_ready, observe()} !== {2'b10, exp})
                        $display("FAIL rand_hold_%0d: got %h required %h", i, {bus.out_valid, bus.in_ready, observe()}, {2'b10, exp});
                    else n_pass++;
                end
                bus.out_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
